// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared ID/EX pipeline definitions: control-bundle layout, width defaults,
// flush-priority encoding and the per-cycle stage action decode.
package id_ex_pipe_reg_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 4;
  localparam int NUM_SRC_DEF = 2;
  localparam int CNT_W_DEF   = 4;

  // Control bundle layout, LSB first: we, mem_we, mem_re, hlt, func, imm.
  localparam int CTRL_WE_BIT     = 0;
  localparam int CTRL_MEM_WE_BIT = CTRL_WE_BIT + 1;
  localparam int CTRL_MEM_RE_BIT = CTRL_MEM_WE_BIT + 1;
  localparam int CTRL_HLT_BIT    = CTRL_MEM_RE_BIT + 1;
  localparam int CTRL_FUNC_LSB   = CTRL_HLT_BIT + 1;
  localparam int CTRL_FUNC_W     = 4;
  localparam int CTRL_IMM_LSB    = CTRL_FUNC_LSB + CTRL_FUNC_W;
  localparam int CTRL_IMM_W      = 16;
  localparam int CTRL_W_DEF      = CTRL_IMM_LSB + CTRL_IMM_W;

  localparam logic FLUSH_PRI_STALL = 1'b0;
  localparam logic FLUSH_PRI_FLUSH = 1'b1;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_BUBBLE = 2'd2
  } stage_mode_e;

  function automatic stage_mode_e decode_mode(input logic stall, input logic flush,
                                              input logic flush_pri);
    stage_mode_e mode;
    if (stall && flush) begin
      mode = (flush_pri == FLUSH_PRI_FLUSH) ? MODE_BUBBLE : MODE_HOLD;
    end else if (flush) begin
      mode = MODE_BUBBLE;
    end else if (stall) begin
      mode = MODE_HOLD;
    end else begin
      mode = MODE_LOAD;
    end
    return mode;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute stage bus: hazard controls, instruction fields, bypass
// bus and the registered stage contents.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 2,
  parameter int CTRL_W  = 24,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 4
);
  logic                      stall_in;
  logic                      flush_in;
  logic                      valid_in;
  logic [CTRL_W-1:0]         ctrl_in;
  logic [ADDR_W-1:0]         dst_addr_in;
  logic [NUM_SRC*ADDR_W-1:0] src_addr_in;
  logic [NUM_SRC*DATA_W-1:0] src_in;
  logic [NUM_SRC-1:0]        byp_req_in;
  logic                      byp_valid_in;
  logic [ADDR_W-1:0]         byp_addr_in;
  logic [DATA_W-1:0]         byp_data_in;
  logic                      valid_out;
  logic [CTRL_W-1:0]         ctrl_out;
  logic [ADDR_W-1:0]         dst_addr_out;
  logic [NUM_SRC*DATA_W-1:0] src_out;
  logic [NUM_SRC-1:0]        src_pending_out;
  logic                      pending_any_out;
  logic [CNT_W-1:0]          stall_cnt_out;

  modport master (
    output stall_in, flush_in, valid_in, ctrl_in, dst_addr_in, src_addr_in, src_in,
           byp_req_in, byp_valid_in, byp_addr_in, byp_data_in,
    input  valid_out, ctrl_out, dst_addr_out, src_out, src_pending_out,
           pending_any_out, stall_cnt_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, ctrl_in, dst_addr_in, src_addr_in, src_in,
           byp_req_in, byp_valid_in, byp_addr_in, byp_data_in,
    output valid_out, ctrl_out, dst_addr_out, src_out, src_pending_out,
           pending_any_out, stall_cnt_out
  );
endinterface

// File: rtl/id_ex_pipe_reg_src_lane_reg.sv
// One operand lane of the ID/EX register: data, source address and a pending
// bit that is resolved from the late-load bypass bus.
module src_lane_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  stage_mode_e       mode_in,
  input  logic              valid_in,
  input  logic              req_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              byp_valid_in,
  input  logic [ADDR_W-1:0] byp_addr_in,
  input  logic [DATA_W-1:0] byp_data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              pending_out
);
  logic [DATA_W-1:0] data_r;
  logic [ADDR_W-1:0] addr_r;
  logic              pend_r;

  // Lane state: load (with same-cycle bypass), hold (with late capture) or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {DATA_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
      pend_r <= 1'b0;
    end else begin
      case (mode_in)
        MODE_LOAD: begin
          addr_r <= addr_in;
          if (req_in && byp_valid_in && valid_in && (byp_addr_in == addr_in)) begin
            data_r <= byp_data_in;
            pend_r <= 1'b0;
          end else begin
            data_r <= data_in;
            pend_r <= req_in & valid_in;
          end
        end
        MODE_HOLD: begin
          if (pend_r && byp_valid_in && (byp_addr_in == addr_r)) begin
            data_r <= byp_data_in;
            pend_r <= 1'b0;
          end
        end
        default: begin
          data_r <= {DATA_W{1'b0}};
          addr_r <= {ADDR_W{1'b0}};
          pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_r;
  assign pending_out = pend_r;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/control/destination, NUM_SRC operand lanes
// with late-operand capture, and a saturating stall-cycle counter.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int CTRL_W    = CTRL_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FLUSH_PRI = 0
) (
  input logic                 clk,
  input logic                 rst,
  id_ex_pipe_reg_if.slave     bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic FLUSH_PRI_L = (FLUSH_PRI != 0) ? FLUSH_PRI_FLUSH : FLUSH_PRI_STALL;

  stage_mode_e               mode_s;
  logic                      valid_r;
  logic [CTRL_W-1:0]         ctrl_r;
  logic [ADDR_W-1:0]         dst_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [NUM_SRC*DATA_W-1:0] src_s;
  logic [NUM_SRC-1:0]        pend_s;

  assign mode_s = decode_mode(bus.stall_in, bus.flush_in, FLUSH_PRI_L);

  // Stage-wide fields and the stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      dst_r   <= {ADDR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (mode_s)
        MODE_LOAD: begin
          valid_r <= bus.valid_in;
          ctrl_r  <= bus.ctrl_in;
          dst_r   <= bus.dst_addr_in;
          cnt_r   <= {CNT_W{1'b0}};
        end
        MODE_HOLD: begin
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          valid_r <= 1'b0;
          ctrl_r  <= {CTRL_W{1'b0}};
          dst_r   <= {ADDR_W{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
    src_lane_reg #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .mode_in      (mode_s),
      .valid_in     (bus.valid_in),
      .req_in       (bus.byp_req_in[k]),
      .addr_in      (bus.src_addr_in[k*ADDR_W +: ADDR_W]),
      .data_in      (bus.src_in[k*DATA_W +: DATA_W]),
      .byp_valid_in (bus.byp_valid_in),
      .byp_addr_in  (bus.byp_addr_in),
      .byp_data_in  (bus.byp_data_in),
      .data_out     (src_s[k*DATA_W +: DATA_W]),
      .pending_out  (pend_s[k])
    );
  end

  assign bus.valid_out       = valid_r;
  assign bus.ctrl_out        = ctrl_r;
  assign bus.dst_addr_out    = dst_r;
  assign bus.src_out         = src_s;
  assign bus.src_pending_out = pend_s;
  assign bus.pending_any_out = |pend_s;
  assign bus.stall_cnt_out   = cnt_r;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Drives one FLUSH_PRI=0 and one FLUSH_PRI=1 instance with identical stimulus
// and compares both against a per-instance behavioural model.
module tb_id_ex_pipe_reg;
  localparam int NS = 2;

  logic clk;
  logic rst;
  logic        stall_v, flush_v, valid_v, bv_v;
  logic [23:0] ctrl_v;
  logic [3:0]  dst_v, ba_v;
  logic [7:0]  saddr_v;
  logic [31:0] src_v;
  logic [1:0]  req_v;
  logic [15:0] bd_v;

  int n_checks;
  int n_pass;

  // model state, index 0 = stall-priority instance, 1 = flush-priority instance
  logic        m_valid [2];
  logic [23:0] m_ctrl  [2];
  logic [3:0]  m_dst   [2];
  int          m_cnt   [2];
  logic [15:0] m_src   [2][NS];
  logic [3:0]  m_addr  [2][NS];
  logic        m_pend  [2][NS];

  id_ex_pipe_reg_if #(.DATA_W(16), .NUM_SRC(NS), .CTRL_W(24), .ADDR_W(4), .CNT_W(4)) bus0 ();
  id_ex_pipe_reg_if #(.DATA_W(16), .NUM_SRC(NS), .CTRL_W(24), .ADDR_W(4), .CNT_W(4)) bus1 ();

  assign bus0.stall_in = stall_v;      assign bus1.stall_in = stall_v;
  assign bus0.flush_in = flush_v;      assign bus1.flush_in = flush_v;
  assign bus0.valid_in = valid_v;      assign bus1.valid_in = valid_v;
  assign bus0.ctrl_in = ctrl_v;        assign bus1.ctrl_in = ctrl_v;
  assign bus0.dst_addr_in = dst_v;     assign bus1.dst_addr_in = dst_v;
  assign bus0.src_addr_in = saddr_v;   assign bus1.src_addr_in = saddr_v;
  assign bus0.src_in = src_v;          assign bus1.src_in = src_v;
  assign bus0.byp_req_in = req_v;      assign bus1.byp_req_in = req_v;
  assign bus0.byp_valid_in = bv_v;     assign bus1.byp_valid_in = bv_v;
  assign bus0.byp_addr_in = ba_v;      assign bus1.byp_addr_in = ba_v;
  assign bus0.byp_data_in = bd_v;      assign bus1.byp_data_in = bd_v;

  id_ex_pipe_reg #(.DATA_W(16), .NUM_SRC(NS), .CTRL_W(24), .ADDR_W(4), .CNT_W(4),
                   .FLUSH_PRI(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  id_ex_pipe_reg #(.DATA_W(16), .NUM_SRC(NS), .CTRL_W(24), .ADDR_W(4), .CNT_W(4),
                   .FLUSH_PRI(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_valid[p] = 1'b0; m_ctrl[p] = 24'd0; m_dst[p] = 4'd0; m_cnt[p] = 0;
      for (int k = 0; k < NS; k++) begin
        m_src[p][k] = 16'd0; m_addr[p][k] = 4'd0; m_pend[p][k] = 1'b0;
      end
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    for (int p = 0; p < 2; p++) begin
      bit hold, bubble;
      hold   = stall_v && !(flush_v && p == 1);
      bubble = flush_v && !hold;
      if (hold) begin
        m_cnt[p] = (m_cnt[p] < 15) ? m_cnt[p] + 1 : 15;
        for (int k = 0; k < NS; k++)
          if (m_pend[p][k] && bv_v && m_addr[p][k] == ba_v) begin
            m_src[p][k] = bd_v; m_pend[p][k] = 1'b0;
          end
      end else if (bubble) begin
        m_valid[p] = 1'b0; m_ctrl[p] = 24'd0; m_dst[p] = 4'd0; m_cnt[p] = 0;
        for (int k = 0; k < NS; k++) begin
          m_src[p][k] = 16'd0; m_addr[p][k] = 4'd0; m_pend[p][k] = 1'b0;
        end
      end else begin
        m_valid[p] = valid_v; m_ctrl[p] = ctrl_v; m_dst[p] = dst_v; m_cnt[p] = 0;
        for (int k = 0; k < NS; k++) begin
          logic [3:0] a;
          a = saddr_v[k*4 +: 4];
          m_addr[p][k] = a;
          if (req_v[k] && bv_v && valid_v && ba_v == a) begin
            m_src[p][k] = bd_v; m_pend[p][k] = 1'b0;
          end else begin
            m_src[p][k] = src_v[k*16 +: 16]; m_pend[p][k] = req_v[k] & valid_v;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int p = 0; p < 2; p++) begin
      logic [31:0] exp_src;
      logic [1:0]  exp_pend;
      for (int k = 0; k < NS; k++) begin
        exp_src[k*16 +: 16] = m_src[p][k];
        exp_pend[k] = m_pend[p][k];
      end
      check_eq($sformatf("%s.valid%0d", ctx, p), 64'(p == 0 ? bus0.valid_out : bus1.valid_out), 64'(m_valid[p]));
      check_eq($sformatf("%s.ctrl%0d", ctx, p), 64'(p == 0 ? bus0.ctrl_out : bus1.ctrl_out), 64'(m_ctrl[p]));
      check_eq($sformatf("%s.dst%0d", ctx, p), 64'(p == 0 ? bus0.dst_addr_out : bus1.dst_addr_out), 64'(m_dst[p]));
      check_eq($sformatf("%s.src%0d", ctx, p), 64'(p == 0 ? bus0.src_out : bus1.src_out), 64'(exp_src));
      check_eq($sformatf("%s.pend%0d", ctx, p), 64'(p == 0 ? bus0.src_pending_out : bus1.src_pending_out), 64'(exp_pend));
      check_eq($sformatf("%s.pany%0d", ctx, p), 64'(p == 0 ? bus0.pending_any_out : bus1.pending_any_out), 64'(|exp_pend));
      check_eq($sformatf("%s.cnt%0d", ctx, p), 64'(p == 0 ? bus0.stall_cnt_out : bus1.stall_cnt_out), 64'(m_cnt[p]));
    end
  endtask

  task automatic set_in(input logic st, input logic fl, input logic va, input logic [23:0] c,
                        input logic [3:0] d, input logic [7:0] sa, input logic [31:0] s,
                        input logic [1:0] rq, input logic b, input logic [3:0] a, input logic [15:0] bd);
    stall_v = st; flush_v = fl; valid_v = va; ctrl_v = c; dst_v = d; saddr_v = sa;
    src_v = s; req_v = rq; bv_v = b; ba_v = a; bd_v = bd;
  endtask

  task automatic cycle(input string ctx);
    model_step();
    @(posedge clk);
    #1;
    check_all(ctx);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 24'd0, 4'd0, 8'd0, 32'd0, 2'b00, 1'b0, 4'd0, 16'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    rst = 1'b0;

    // load something, then hit reset mid-cycle while stalled with a pending lane
    set_in(1'b0, 1'b0, 1'b1, 24'h123456, 4'd9, 8'h21, 32'hAAAA5555, 2'b01, 1'b0, 4'd0, 16'd0);
    cycle("pre");
    set_in(1'b1, 1'b0, 1'b1, 24'h0, 4'd0, 8'h0, 32'h0, 2'b00, 1'b0, 4'd0, 16'd0);
    cycle("pre_hold");
    @(posedge clk); #3;
    rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    set_in(1'b0, 1'b0, 1'b1, 24'h00A5A5, 4'd2, 8'h00, {16'h1234, 16'h5678}, 2'b00, 1'b0, 4'd0, 16'd0);
    cycle("load");
    check_eq("load_src", 64'(bus0.src_out), 64'h12345678);
    check_eq("load_pend", 64'(bus0.src_pending_out), 64'd0);

    // late capture after two held cycles
    set_in(1'b0, 1'b0, 1'b1, 24'h000011, 4'd4, 8'h13, {16'hCAFE, 16'h0000}, 2'b01, 1'b0, 4'd0, 16'd0);
    cycle("late_ld");
    check_eq("late_pend_set", 64'(bus0.src_pending_out), 64'd1);
    set_in(1'b1, 1'b0, 1'b0, 24'd0, 4'd0, 8'd0, 32'd0, 2'b00, 1'b0, 4'd3, 16'hBEEF);
    cycle("late_h1");
    cycle("late_h2");
    bv_v = 1'b1;
    cycle("late_cap");
    check_eq("late_src0", 64'(bus0.src_out[15:0]), 64'hBEEF);
    check_eq("late_src1", 64'(bus0.src_out[31:16]), 64'hCAFE);
    check_eq("late_pend_clr", 64'(bus0.src_pending_out), 64'd0);

    // same-cycle bypass on load
    set_in(1'b0, 1'b0, 1'b1, 24'h000022, 4'd5, 8'h50, {16'h1111, 16'h2222}, 2'b10, 1'b1, 4'd5, 16'h0F0F);
    cycle("same_cyc");
    check_eq("same_src1", 64'(bus0.src_out[31:16]), 64'h0F0F);
    check_eq("same_pend", 64'(bus0.src_pending_out), 64'd0);

    // stall and flush together
    set_in(1'b1, 1'b1, 1'b1, 24'h0, 4'd0, 8'd0, 32'd0, 2'b00, 1'b0, 4'd0, 16'd0);
    cycle("pri");
    check_eq("pri0_valid", 64'(bus0.valid_out), 64'd1);
    check_eq("pri0_cnt", 64'(bus0.stall_cnt_out), 64'd1);
    check_eq("pri1_valid", 64'(bus1.valid_out), 64'd0);

    // counter saturation
    set_in(1'b0, 1'b0, 1'b1, 24'h000033, 4'd1, 8'd0, 32'h01020304, 2'b00, 1'b0, 4'd0, 16'd0);
    cycle("sat_ld");
    stall_v = 1'b1;
    for (int i = 0; i < 20; i++) cycle("sat");
    check_eq("sat_cnt", 64'(bus0.stall_cnt_out), 64'd15);
    stall_v = 1'b0;
    cycle("sat_clr");
    check_eq("sat_clr_cnt", 64'(bus0.stall_cnt_out), 64'd0);

    // address mismatch keeps lane pending
    set_in(1'b0, 1'b0, 1'b1, 24'h000044, 4'd7, 8'h07, {16'h3333, 16'h4444}, 2'b01, 1'b0, 4'd0, 16'd0);
    cycle("mis_ld");
    set_in(1'b1, 1'b0, 1'b0, 24'd0, 4'd0, 8'd0, 32'd0, 2'b00, 1'b1, 4'd6, 16'hDEAD);
    for (int i = 0; i < 3; i++) cycle("mis");
    check_eq("mis_src0", 64'(bus0.src_out[15:0]), 64'h4444);
    check_eq("mis_pany", 64'(bus0.pending_any_out), 64'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom();
      stall_v = (r[3:0] < 4'd5);
      flush_v = (r[7:4] < 4'd3);
      valid_v = r[8];
      req_v   = r[10:9];
      bv_v    = r[11];
      ba_v    = {2'b00, r[13:12]};
      saddr_v = {2'b00, r[15:14], 2'b00, r[17:16]};
      dst_v   = r[21:18];
      r = $urandom();
      ctrl_v  = r[23:0];
      src_v   = $urandom();
      r = $urandom();
      bd_v    = r[15:0];
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register holding a valid bit, a control bundle, a destination address and NUM_SRC operand lanes. It adds per-lane late-operand capture: a lane waiting on a load result is filled from the bypass bus while the stage is held. It also has selectable stall/flush priority and a saturating stall-cycle counter. It sits between decode and execute, driven by the hazard unit's stall/flush lines.

## Interface
- DATA_W, 16, operand lane width
- NUM_SRC, 2, number of operand lanes (1..4)
- CTRL_W, 24, width of packed control bundle (we, mem_we, mem_re, hlt, func, etc.)
- ADDR_W, 4, register address width
- CNT_W, 4, stall counter width
- FLUSH_PRI, 0, 0: stall beats flush; 1: flush beats stall
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- stall_in  in  1  hold stage contents
- flush_in  in  1  insert bubble
- valid_in  in  1  ID has an instruction
- ctrl_in  in  CTRL_W  control bundle
- dst_addr_in  in  ADDR_W  destination register
- src_addr_in  in  NUM_SRC*ADDR_W  source register per lane, lane k at [k*ADDR_W +: ADDR_W]
- src_in  in  NUM_SRC*DATA_W  operand values, lane k at [k*DATA_W +: DATA_W]
- byp_req_in  in  NUM_SRC  lane k value is stale and waits for a load result
- byp_valid_in  in  1  late load result present this cycle
- byp_addr_in  in  ADDR_W  destination of late result
- byp_data_in  in  DATA_W  late result data
- valid_out  out  1  stage holds a live instruction
- ctrl_out  out  CTRL_W  registered control
- dst_addr_out  out  ADDR_W  registered destination
- src_out  out  NUM_SRC*DATA_W  registered operands
- src_pending_out  out  NUM_SRC  lane k still waiting for bypass
- pending_any_out  out  1  OR of src_pending_out; feeds the hazard unit
- stall_cnt_out  out  CNT_W  consecutive stall cycles, saturating

## Operation
- Per-cycle action, in priority order: rst, then hold or bubble (order set by FLUSH_PRI), then load.
- **Load** (no stall, no flush):
  - Capture valid_in, ctrl_in, dst_addr_in, src_addr_in and src_in.
  - For each lane k with byp_req_in[k]=1: if byp_valid_in=1, valid_in=1 and byp_addr_in equals lane k's address, store byp_data_in and clear pending[k]. Otherwise store src_in and set pending[k]=valid_in.
- **Bubble** (flush):
  - valid_out, ctrl_out, dst_addr_out, src_out and pending all become 0.
  - Stored src addresses become 0.
- **Hold** (stall):
  - All fields keep their values.
  - Exception: each pending lane whose stored src address equals byp_addr_in while byp_valid_in=1 takes byp_data_in and clears its pending bit.
  - Several lanes with the same address all capture in the same cycle.
  - Non-pending lanes never change during a hold.
- **Stall and flush together:**
  - FLUSH_PRI=0: hold, including bypass capture.
  - FLUSH_PRI=1: bubble.
- stall_cnt increments by 1 each hold cycle and saturates at 2^CNT_W-1. It clears to 0 on any load or bubble cycle.
- Address 0 is a normal address; there is no zero-register special case.

## Timing
- Reset values: every output, pending bit, stored address and stall_cnt is 0.
- Reset asserted mid-stall or with pending lanes clears everything in the same cycle, asynchronously.
- Latency: inputs appear on the outputs one cycle after a load edge.
- Bypass capture takes effect on the edge where byp_valid_in is sampled. src_pending_out drops on that same edge.
- pending_any_out is combinational from the pending registers, with no input-to-output path.
- No combinational path from any input to any output.

## Structure
- Shared pipeline package holds:
  - the control-bundle field offsets that make up CTRL_W;
  - ADDR_W/DATA_W defaults;
  - the FLUSH_PRI encoding constants.
- One sub-module, `src_lane_reg`, instantiated NUM_SRC times. Each instance holds the data, address and pending bit, plus the load/hold/capture/bubble logic for its lane.
- The top level owns valid, ctrl, dst, the mode decode and stall_cnt.

## Test plan
- Reset and load: assert rst mid-cycle, release, then load ctrl=0x00A5A5, src={0x1234,0x5678}, valid=1 → outputs 0 during reset; the next edge shows the loaded values with pending=00.
- Late capture: load with byp_req=01 and src_addr0=3, hold 2 cycles, then drive byp_valid=1, byp_addr=3, data=0xBEEF → src0=0xBEEF, pending 1→0 on that edge, src1 unchanged.
- Same-cycle bypass on load: byp_req=10, src_addr1=5, byp_valid=1, byp_addr=5, data=0x0F0F → src1=0x0F0F, pending=00 immediately.
- Priority: stall=flush=1 with valid stage → FLUSH_PRI=0 keeps contents and stall_cnt increments; FLUSH_PRI=1 gives valid_out=0, pending=00.
- Counter saturation (CNT_W=4): 20 consecutive stalls → stall_cnt stops at 15; one load → 0.
- Address mismatch: pending lane addr 7, bypass to addr 6 for 3 held cycles → lane unchanged, pending stays 1, pending_any_out=1.
